// File: rtl/encoder83_pri_pkg.sv
// Shared constants for the registered 8-to-3 priority encoder (74x148 style).
package encoder83_pri_pkg;

    localparam int N_IN = 8;
    localparam logic [2:0] CODE_IDLE = 3'b111;
    localparam logic       EO_RESET  = 1'b1;

endpackage : encoder83_pri_pkg

// File: rtl/encoder83_pri_comb.sv
// Combinational 74x148 priority logic: active-low requests, enable and outputs.
module encoder83_pri_comb
    import encoder83_pri_pkg::*;
(
    input  logic [N_IN-1:0] iData,
    input  logic            iEI,
    output logic [2:0]      oData,
    output logic            oEO
);

    // Highest-index low bit wins; all-high with the encoder enabled is the idle code.
    always_comb begin
        oData = CODE_IDLE;
        oEO   = EO_RESET;
        if (iEI == 1'b1) begin
            oData = CODE_IDLE;
            oEO   = 1'b1;
        end else begin
            oEO = 1'b1;
            casez (iData)
                8'b0???????: oData = 3'b000;
                8'b10??????: oData = 3'b001;
                8'b110?????: oData = 3'b010;
                8'b1110????: oData = 3'b011;
                8'b11110???: oData = 3'b100;
                8'b111110??: oData = 3'b101;
                8'b1111110?: oData = 3'b110;
                8'b11111110: oData = 3'b111;
                default: begin
                    oData = CODE_IDLE;
                    oEO   = 1'b0;
                end
            endcase
        end
    end

endmodule : encoder83_pri_comb

// File: rtl/encoder83_pri.sv
// Registered 8-to-3 priority encoder: one-cycle latency, outputs straight from flops.
module encoder83_pri
    import encoder83_pri_pkg::*;
(
    input  logic            iClk,
    input  logic            iRst,
    input  logic [N_IN-1:0] iData,
    input  logic            iEI,
    output logic [2:0]      oData,
    output logic            oEO
);

    logic [2:0] data_d;
    logic       eo_d;
    logic [2:0] data_q;
    logic       eo_q;

    encoder83_pri_comb u_comb (
        .iData (iData),
        .iEI   (iEI),
        .oData (data_d),
        .oEO   (eo_d)
    );

    // Output register; reset forces the disabled encoding and drops any pending result.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            data_q <= CODE_IDLE;
            eo_q   <= EO_RESET;
        end else begin
            data_q <= data_d;
            eo_q   <= eo_d;
        end
    end

    assign oData = data_q;
    assign oEO   = eo_q;

endmodule : encoder83_pri

// File: tb/tb_encoder83_pri.sv
// Directed self-checking bench for encoder83_pri.
module tb_encoder83_pri;

    logic       iClk;
    logic       iRst;
    logic [7:0] iData;
    logic       iEI;
    logic [2:0] oData;
    logic       oEO;

    int pass_cnt;
    int total_cnt;

    encoder83_pri dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iData (iData),
        .iEI   (iEI),
        .oData (oData),
        .oEO   (oEO)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst  = 1'b1;
        iEI   = 1'b0;
        iData = 8'h00;
        #3;
        total_cnt++;
        if (oData !== 3'b111) $display("FAIL reset_async_data: got %b want 111", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b1) $display("FAIL reset_async_eo: got %b want 1", oEO);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (oData !== 3'b111) $display("FAIL reset_held_data: got %b want 111", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b1) $display("FAIL reset_held_eo: got %b want 1", oEO);
        else pass_cnt++;
        iRst = 1'b0;
        tick();
        total_cnt++;
        if (oData !== 3'b000) $display("FAIL reset_release_data: got %b want 000", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b1) $display("FAIL reset_release_eo: got %b want 1", oEO);
        else pass_cnt++;
    endtask

    task automatic test_disabled();
        logic [7:0] vec [3];
        vec[0] = 8'hFF;
        vec[1] = 8'h00;
        vec[2] = 8'h5A;
        iEI = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iData = vec[i];
            tick();
            total_cnt++;
            if (oData !== 3'b111) $display("FAIL disabled_data[%h]: got %b want 111", vec[i], oData);
            else pass_cnt++;
            total_cnt++;
            if (oEO !== 1'b1) $display("FAIL disabled_eo[%h]: got %b want 1", vec[i], oEO);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle();
        iEI   = 1'b0;
        iData = 8'hFF;
        tick();
        total_cnt++;
        if (oData !== 3'b111) $display("FAIL idle_data: got %b want 111", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b0) $display("FAIL idle_eo: got %b want 0", oEO);
        else pass_cnt++;
    endtask

    task automatic test_priority_sweep();
        logic [7:0] vec [8];
        logic [2:0] exp [8];
        vec[0] = 8'h00; exp[0] = 3'b000;
        vec[1] = 8'h80; exp[1] = 3'b001;
        vec[2] = 8'hC0; exp[2] = 3'b010;
        vec[3] = 8'hE0; exp[3] = 3'b011;
        vec[4] = 8'hF0; exp[4] = 3'b100;
        vec[5] = 8'hF8; exp[5] = 3'b101;
        vec[6] = 8'hFC; exp[6] = 3'b110;
        vec[7] = 8'hFE; exp[7] = 3'b111;
        iEI = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iData = vec[i];
            for (int c = 0; c < 4; c++) begin
                tick();
                total_cnt++;
                if (oData !== exp[i])
                    $display("FAIL sweep_data[%h] cyc%0d: got %b want %b", vec[i], c, oData, exp[i]);
                else pass_cnt++;
                total_cnt++;
                if (oEO !== 1'b1)
                    $display("FAIL sweep_eo[%h] cyc%0d: got %b want 1", vec[i], c, oEO);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_single_bit();
        iEI   = 1'b0;
        iData = 8'hF7;
        tick();
        total_cnt++;
        if (oData !== 3'b100) $display("FAIL single_bit3_data: got %b want 100", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b1) $display("FAIL single_bit3_eo: got %b want 1", oEO);
        else pass_cnt++;
        iData = 8'hF5;
        tick();
        total_cnt++;
        if (oData !== 3'b100) $display("FAIL bits31_data: got %b want 100", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b1) $display("FAIL bits31_eo: got %b want 1", oEO);
        else pass_cnt++;
    endtask

    task automatic test_midrun_reset();
        iEI   = 1'b0;
        iData = 8'h80;
        tick();
        total_cnt++;
        if (oData !== 3'b001) $display("FAIL midrun_pre_data: got %b want 001", oData);
        else pass_cnt++;
        iData = 8'hC0;
        #2;
        iRst = 1'b1;
        #1;
        total_cnt++;
        if (oData !== 3'b111) $display("FAIL midrun_async_data: got %b want 111", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b1) $display("FAIL midrun_async_eo: got %b want 1", oEO);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (oData !== 3'b111) $display("FAIL midrun_held_data: got %b want 111", oData);
        else pass_cnt++;
        iRst = 1'b0;
        tick();
        total_cnt++;
        if (oData !== 3'b010) $display("FAIL midrun_recover_data: got %b want 010", oData);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        iEI   = 1'b0;
        iData = 8'hFE;
        tick();
        iData = 8'h00;
        tick();
        total_cnt++;
        if (oData !== 3'b000) $display("FAIL b2b_first_data: got %b want 000", oData);
        else pass_cnt++;
        iEI = 1'b1;
        tick();
        total_cnt++;
        if (oData !== 3'b111) $display("FAIL b2b_disable_data: got %b want 111", oData);
        else pass_cnt++;
        total_cnt++;
        if (oEO !== 1'b1) $display("FAIL b2b_disable_eo: got %b want 1", oEO);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        iRst  = 1'b1;
        iEI   = 1'b1;
        iData = 8'hFF;
        test_reset();
        test_disabled();
        test_idle();
        test_priority_sweep();
        test_single_bit();
        test_midrun_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_encoder83_pri

// File: doc/encoder83_pri.md
ENCODER83_PRI -- requirements
Module: encoder83_pri

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 8 inputs and 3 code bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 iClk  input  1  clock; all state updates on its rising edge.
REQ-004 iRst  input  1  asynchronous active-high reset.
REQ-005 iData  input  8  request lines, active-low; bit 7 has highest priority, bit 0 lowest.
REQ-006 iEI  input  1  enable input, active-low (0 = encoder enabled).
REQ-007 oData  output  3  encoded index of the winning request, active-low (bitwise complement of the index), registered.
REQ-008 oEO  output  1  enable output, active-low (0 = enabled but no request active), registered.

Function
REQ-009 Encoding SHALL follow the 74x148 truth table, evaluated on the inputs sampled at each rising iClk edge.
REQ-010 iEI=1: the next oData SHALL be 3'b111 and oEO SHALL be 1, regardless of iData.
REQ-011 iEI=0, iData=8'hFF (no request): the next oData SHALL be 3'b111 and oEO SHALL be 0.
REQ-012 iEI=0, at least one iData bit 0: let k = highest index with iData[k]=0; the next oData SHALL be ~k[2:0] and oEO SHALL be 1.
REQ-013 Lower-priority bits SHALL be don't-care once a higher bit is 0 (e.g. iData=8'h00 yields oData=3'b000).
REQ-014 Latency SHALL be exactly one iClk cycle from input change to registered output, with no handshake.
REQ-015 Outputs SHALL hold their value between edges and SHALL be glitch-free (driven directly from flops).
REQ-016 Inputs are synchronous to iClk; X/Z on iData or iEI is outside the supported input space.

Reset
REQ-017 While iRst=1, oData SHALL be 3'b111 and oEO SHALL be 1 (the disabled encoding), asynchronously.
REQ-018 On iRst deassertion, the first rising iClk edge SHALL load the encoding of the current inputs.
REQ-019 Reset asserted mid-operation SHALL immediately force the reset values and discard the pending result.

Structure
REQ-020 A shared package encoder83_pri_pkg SHALL hold the constants CODE_IDLE=3'b111, EO_RESET=1'b1 and N_IN=8.
REQ-021 Combinational priority logic SHALL live in one sub-module, encoder83_pri_comb, with ports iData, iEI, oData, oEO and no clock.
REQ-022 The top level SHALL instantiate encoder83_pri_comb and register its outputs with the asynchronous reset.

Verification
REQ-023 Reset: iRst=1 with iEI=0 and iData=8'h00 -> oData=3'b111 and oEO=1 during reset; one cycle after release, oData=3'b000 and oEO=1.
REQ-024 Disabled: iEI=1 with iData in {8'hFF, 8'h00, 8'h5A} -> oData=3'b111 and oEO=1 each cycle.
REQ-025 Idle: iEI=0 and iData=8'hFF -> oData=3'b111 and oEO=0.
REQ-026 Priority sweep, iEI=0, each input held 4 cycles:
- iData sequence: 8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE.
- Required oData, one cycle later: 000, 001, 010, 011, 100, 101, 110, 111.
- oEO=1 throughout.
REQ-027 Single-bit: iEI=0, iData with only bit 3 low (8'hF7) -> oData=3'b100 and oEO=1; with bits 3 and 1 low (8'hF5) -> oData=3'b100.
REQ-028 Mid-run reset: assert iRst asynchronously between edges while oData=3'b001 -> outputs go to 111/1 before the next edge.
